// File: rtl/imem_loader_if.sv
// Boot-loader bus: byte stream in, instruction-memory write port and core status out.
interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst;
    logic              busy;
    logic              done;
    logic              err;
    logic [15:0]       word_count;

    modport master (
        output start, rx_data, rx_valid,
        input  rx_ready, imem_we, imem_addr, imem_wdata,
        input  core_rst, busy, done, err, word_count
    );

    modport slave (
        input  start, rx_data, rx_valid,
        output rx_ready, imem_we, imem_addr, imem_wdata,
        output core_rst, busy, done, err, word_count
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte image into instruction memory and releases core reset when complete.
// Latency: 1 start + 2 header + 5 cycles per word with the stream never stalling.
// Backpressure: rx_ready drops outside LEN_LO/LEN_HI/DATA, including the single WRITE cycle per word.
module imem_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] MAX_L = 17'(MAX_WORDS);

    state_t      state, state_nxt;
    logic [15:0] len;
    logic [15:0] word_idx;
    logic [15:0] word_count;
    logic [1:0]  byte_idx;
    logic [31:0] wdata;
    logic [15:0] len_full;
    logic        rdy;
    logic        xfer;
    logic        restart;

    assign len_full = {bus.rx_data, len[7:0]};
    assign xfer     = bus.rx_valid & rdy;
    assign restart  = bus.start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR));

    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                rdy = 1'b1;
                if (bus.rx_valid) state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                rdy = 1'b1;
                if (bus.rx_valid) begin
                    if ((len_full == 16'd0) || ({1'b0, len_full} > MAX_L))
                        state_nxt = S_ERR;
                    else
                        state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                rdy = 1'b1;
                if (bus.rx_valid && (byte_idx == 2'd3)) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                state_nxt = ((word_idx + 16'd1) == len) ? S_DONE : S_DATA;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            len        <= '0;
            byte_idx   <= '0;
            word_idx   <= '0;
            word_count <= '0;
            wdata      <= '0;
        end else begin
            if (restart) begin
                word_idx   <= '0;
                word_count <= '0;
            end
            case (state)
                S_LEN_LO: if (xfer) len[7:0] <= bus.rx_data;
                S_LEN_HI: begin
                    if (xfer && (state_nxt == S_DATA)) begin
                        len      <= len_full;
                        byte_idx <= '0;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        wdata[8*byte_idx +: 8] <= bus.rx_data;
                        byte_idx               <= byte_idx + 2'd1;
                    end
                end
                S_WRITE: begin
                    word_idx   <= word_idx + 16'd1;
                    word_count <= word_count + 16'd1;
                    byte_idx   <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.rx_ready   = rdy;
    assign bus.imem_we    = (state == S_WRITE);
    assign bus.imem_addr  = word_idx[ADDR_W-1:0];
    assign bus.imem_wdata = wdata;
    assign bus.busy       = (state == S_LEN_LO) | (state == S_LEN_HI) |
                            (state == S_DATA)   | (state == S_WRITE);
    assign bus.done       = (state == S_DONE);
    assign bus.err        = (state == S_ERR);
    assign bus.core_rst   = (state == S_DONE);
    assign bus.word_count = word_count;
endmodule
